pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between L2 miss fills (line reads) and victim-cache writebacks (line writes).
- Writebacks come from forced evictions and from idle-time cleaning of dirty victim entries.
- Sits between L2, VC control and pmem.
- One pmem transaction outstanding at a time, with fixed priority, an anti-starvation counter and a read-after-write address hazard check.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word).
- LINE_W, 128, line width in bits (lc3b_line).
- MAX_STARVE, 4, consecutive L2 reads granted while a VC write waits before the VC write is forced ahead; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- l2_read  in  1  L2 line-fill request; held until l2_resp
- l2_address  in  ADDR_W  fill address; line-aligned, low 4 bits ignored
- l2_rdata  out  LINE_W  fill data; valid while l2_resp=1
- l2_resp  out  1  one-cycle fill completion
- vc_write  in  1  VC writeback request; held until vc_resp
- vc_urgent  in  1  1 = forced eviction, 0 = idle cleaning; sampled with vc_write
- vc_address  in  ADDR_W  writeback address
- vc_wdata  in  LINE_W  writeback line
- vc_resp  out  1  one-cycle writeback completion
- pmem_read  out  1  pmem read strobe
- pmem_write  out  1  pmem write strobe
- pmem_address  out  ADDR_W  pmem address, low 4 bits forced 0
- pmem_wdata  out  LINE_W  pmem write data
- pmem_rdata  in  LINE_W  pmem read data
- pmem_resp  in  1  pmem completion, one cycle

Behaviour:
- States: IDLE, L2_RD, VC_WR, BREAK.
- Reset: state=IDLE, starve_cnt=0; all outputs 0, including l2_rdata and pmem_address. Reset mid-transaction abandons it. A pmem_resp arriving in IDLE or BREAK is ignored.
- Hazard condition: hazard = l2_read & vc_write & (l2_address[ADDR_W-1:4] == vc_address[ADDR_W-1:4]).
- IDLE arbitration, evaluated every cycle, first match wins:
  - hazard -> VC_WR
  - vc_write & (vc_urgent | starve_cnt==MAX_STARVE) -> VC_WR
  - l2_read -> L2_RD
  - vc_write -> VC_WR (cleaning; only when L2 is not requesting)
  - otherwise stay in IDLE
- Grant latching: on a grant, register pmem_address (the winner's address with low 4 bits zeroed) and, for a write, pmem_wdata. Strobes assert starting the next cycle and hold steady until pmem_resp. Later changes on requester inputs during the transaction are ignored.
- L2_RD: pmem_read=1. On pmem_resp, register l2_rdata <= pmem_rdata, pulse l2_resp the next cycle, go to BREAK.
- VC_WR: pmem_write=1. On pmem_resp, pulse vc_resp the next cycle, go to BREAK.
- BREAK: one cycle with both strobes 0 and the resp pulse active, then IDLE. Requesters drop their request in the resp cycle, so they are not re-granted.
- Latency: request seen in IDLE at cycle t -> strobe from t+1 -> pmem_resp at cycle r -> resp pulse at r+1 -> IDLE at r+2. Minimum round trip is 3 cycles plus pmem latency.
- starve_cnt (4-bit):
  - +1 on each L2_RD grant made while vc_write=1, saturating at MAX_STARVE.
  - Cleared to 0 on any VC_WR grant.
  - Cleared to 0 in IDLE when vc_write=0.
- Simultaneous requests, non-urgent VC with starve_cnt<MAX_STARVE: L2 wins.
- At most one of pmem_read / pmem_write is ever 1. l2_resp and vc_resp are never 1 in the same cycle.
- l2_rdata holds its last value between fills.

Test Plan:
- Lone fill: l2_read, l2_address=0x1238, pmem_resp 5 cycles after strobe with rdata=0xA5..A5 -> pmem_read asserted with pmem_address=0x1230; l2_resp one cycle after pmem_resp with l2_rdata=0xA5..A5; strobe low during BREAK.
- Hazard: l2_read 0x4010 and vc_write 0x401C (non-urgent) in the same cycle -> write first (pmem_write, address 0x4010), vc_resp, then pmem_read 0x4010; no read issued before vc_resp.
- Urgent eviction vs fill: l2_read 0x2000 and vc_write 0x3000 with vc_urgent=1 together -> VC_WR first, then L2_RD.
- Starvation: vc_write held non-urgent (0x5000) while L2 issues back-to-back reads to 0x6000, 0x6010, ... -> exactly 4 L2 grants, then VC_WR, then starve_cnt=0.
- Idle cleaning: only vc_write=1, vc_urgent=0 -> granted immediately; pmem_wdata equals vc_wdata latched at grant even if vc_wdata changes afterwards.
- Reset mid-read: reset asserted during L2_RD -> the following cycle has state IDLE and all outputs 0; a late pmem_resp produces no l2_resp.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Shares the physical-memory port between L2 line fills and victim-cache writebacks, one transaction at a time.
// Latency: grant in IDLE at t, strobe from t+1 until pmem_resp at r, resp pulse at r+1 (BREAK), IDLE again at r+2.
// Backpressure: requesters hold their request until their resp pulse; pmem paces everything through pmem_resp.
module pmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int LINE_W     = 128,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              l2_read,
    input  logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_rdata,
    output logic              l2_resp,

    input  logic              vc_write,
    input  logic              vc_urgent,
    input  logic [ADDR_W-1:0] vc_address,
    input  logic [LINE_W-1:0] vc_wdata,
    output logic              vc_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        L2_RD = 2'd1,
        VC_WR = 2'd2,
        BREAK = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       hazard;
    logic       grant_l2;
    logic       grant_vc;
    logic       unused_addr_bits;

    // Offsets within a line never reach pmem.
    assign unused_addr_bits = ^{l2_address[3:0], vc_address[3:0]};

    // A fill that overlaps a pending writeback must see the written line, so the write goes first.
    assign hazard = l2_read & vc_write & (l2_address[ADDR_W-1:4] == vc_address[ADDR_W-1:4]);

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        grant_l2       = 1'b0;
        grant_vc       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        case (state)
            IDLE: begin
                if (hazard || (vc_write && (vc_urgent || starve_cnt == STARVE_LIMIT)))
                    grant_vc = 1'b1;
                else if (l2_read)
                    grant_l2 = 1'b1;
                else if (vc_write)
                    grant_vc = 1'b1;

                if (grant_vc)
                    state_nxt = VC_WR;
                else if (grant_l2)
                    state_nxt = L2_RD;

                if (grant_vc || !vc_write)
                    starve_cnt_nxt = 4'd0;
                else if (grant_l2 && starve_cnt < STARVE_LIMIT)
                    starve_cnt_nxt = starve_cnt + 4'd1;
            end
            L2_RD: begin
                pmem_read = 1'b1;
                if (pmem_resp)
                    state_nxt = BREAK;
            end
            VC_WR: begin
                pmem_write = 1'b1;
                if (pmem_resp)
                    state_nxt = BREAK;
            end
            BREAK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            l2_rdata     <= '0;
            l2_resp      <= 1'b0;
            vc_resp      <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            l2_resp    <= (state == L2_RD) && pmem_resp;
            vc_resp    <= (state == VC_WR) && pmem_resp;
            if (grant_l2)
                pmem_address <= {l2_address[ADDR_W-1:4], 4'h0};
            if (grant_vc) begin
                pmem_address <= {vc_address[ADDR_W-1:4], 4'h0};
                pmem_wdata   <= vc_wdata;
            end
            if (state == L2_RD && pmem_resp)
                l2_rdata <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic against a transaction-timestamp model.
module tb_pmem_arbiter;
    localparam int ADDR_W     = 16;
    localparam int LINE_W     = 128;
    localparam int MAX_STARVE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              l2_read;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic              vc_write;
    logic              vc_urgent;
    logic [ADDR_W-1:0] vc_address;
    logic [LINE_W-1:0] vc_wdata;
    logic              vc_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_STARVE(MAX_STARVE)) dut (
        .clk(clk), .reset(reset),
        .l2_read(l2_read), .l2_address(l2_address), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .vc_write(vc_write), .vc_urgent(vc_urgent), .vc_address(vc_address), .vc_wdata(vc_wdata),
        .vc_resp(vc_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: one outstanding transaction described by its kind and the cycle stamps of grant and completion.
    bit                m_active = 1'b0;
    int                m_kind   = 0;      // 1 = fill, 2 = writeback
    int                m_resp_n = -100;
    int                m_free_n = 0;
    int                m_cnt    = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [LINE_W-1:0] m_wdata  = '0;
    logic [LINE_W-1:0] m_rdata  = '0;

    bit x_read, x_write, x_l2_resp, x_vc_resp;

    // Stimulus knobs
    int                fixed_lat = -1;
    int                lat_left  = -1;
    bit                use_pat   = 1'b0;
    logic [LINE_W-1:0] rd_pat    = '0;
    bit                spurious  = 1'b0;
    int                p_l2      = 0;
    int                p_vc      = 0;

    // Transactions as observed on the DUT pmem port
    int                log_kind[$];
    logic [ADDR_W-1:0] log_addr[$];
    bit                prev_r = 1'b0;
    bit                prev_w = 1'b0;

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [ADDR_W-1:0] rnd_addr();
        return {4'h8, 6'd0, 2'($urandom_range(0, 3)), 4'($urandom())};
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int win;
        bit haz;
        if (reset) begin
            m_active = 1'b0; m_kind = 0; m_resp_n = -100; m_free_n = cyc + 1;
            m_cnt = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            return;
        end
        if (m_active && pmem_resp) begin
            m_active = 1'b0;
            m_resp_n = cyc;
            m_free_n = cyc + 2;
            if (m_kind == 1) m_rdata = pmem_rdata;
        end else if (!m_active && cyc >= m_free_n) begin
            haz = l2_read && vc_write && (l2_address[15:4] == vc_address[15:4]);
            win = 0;
            if (vc_write && (haz || vc_urgent || m_cnt == MAX_STARVE)) win = 2;
            else if (l2_read) win = 1;
            else if (vc_write) win = 2;
            if (win == 2 || !vc_write) m_cnt = 0;
            else if (win == 1) m_cnt = (m_cnt + 1 > MAX_STARVE) ? MAX_STARVE : m_cnt + 1;
            if (win != 0) begin
                m_active = 1'b1;
                m_kind   = win;
                if (win == 1) m_addr = {l2_address[15:4], 4'h0};
                else begin
                    m_addr  = {vc_address[15:4], 4'h0};
                    m_wdata = vc_wdata;
                end
            end
        end
    endtask

    task automatic compare();
        x_read    = m_active && m_kind == 1;
        x_write   = m_active && m_kind == 2;
        x_l2_resp = (m_resp_n == cyc) && m_kind == 1;
        x_vc_resp = (m_resp_n == cyc) && m_kind == 2;
        chk("pmem_read", LINE_W'(pmem_read), LINE_W'(x_read));
        chk("pmem_write", LINE_W'(pmem_write), LINE_W'(x_write));
        chk("l2_resp", LINE_W'(l2_resp), LINE_W'(x_l2_resp));
        chk("vc_resp", LINE_W'(vc_resp), LINE_W'(x_vc_resp));
        chk("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("l2_rdata", l2_rdata, m_rdata);
        chk("starve_cnt", LINE_W'(dut.starve_cnt), LINE_W'(m_cnt));
        chk("strobe_excl", LINE_W'(pmem_read & pmem_write), '0);
        chk("resp_excl", LINE_W'(l2_resp & vc_resp), '0);
        if (pmem_read && !prev_r) begin log_kind.push_back(1); log_addr.push_back(pmem_address); end
        if (pmem_write && !prev_w) begin log_kind.push_back(2); log_addr.push_back(pmem_address); end
        prev_r = pmem_read;
        prev_w = pmem_write;
    endtask

    task automatic drive();
        if (x_read || x_write) begin
            if (lat_left < 0) lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (lat_left == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = use_pat ? rd_pat : rnd_line();
                lat_left   = -1;
            end else begin
                pmem_resp = 1'b0;
                lat_left--;
            end
        end else begin
            lat_left   = -1;
            pmem_resp  = spurious && ($urandom_range(0, 5) == 0);
            pmem_rdata = rnd_line();
        end
        if (x_l2_resp) l2_read = 1'b0;
        if (x_vc_resp) vc_write = 1'b0;
        if (x_write) vc_wdata = rnd_line();
        l2_address[3:0] = 4'($urandom());
        if (p_l2 > 0 && !l2_read && !x_l2_resp && $urandom_range(0, 99) < p_l2) begin
            l2_read    = 1'b1;
            l2_address = rnd_addr();
        end
        if (p_vc > 0 && !vc_write && !x_vc_resp && $urandom_range(0, 99) < p_vc) begin
            vc_write   = 1'b1;
            vc_urgent  = ($urandom_range(0, 3) == 0);
            vc_address = rnd_addr();
            vc_wdata   = rnd_line();
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
        cyc++;
        drive();
    endtask

    task automatic settle(input string name);
        int k;
        k = 0;
        while ((l2_read || vc_write || m_active || cyc < m_free_n) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: arbiter did not go quiet within 200 cycles", name);
        end
        step();
    endtask

    task automatic log_chk(input string name, input int idx, input int kind, input logic [ADDR_W-1:0] addr);
        if (idx >= log_kind.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: transaction %0d missing, got %0d transactions", name, idx, log_kind.size());
        end else begin
            chk({name, "_kind"}, LINE_W'(log_kind[idx]), LINE_W'(kind));
            chk({name, "_addr"}, LINE_W'(log_addr[idx]), LINE_W'(addr));
        end
    endtask

    task automatic clear_log();
        log_kind.delete();
        log_addr.delete();
    endtask

    initial begin
        int                k;
        bit                l2_gap;
        bit                w_seen;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] w1;

        reset = 1'b1; l2_read = 1'b0; l2_address = '0; vc_write = 1'b0; vc_urgent = 1'b0;
        vc_address = '0; vc_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        step(); step();
        chk("rst_addr", LINE_W'(pmem_address), '0);
        chk("rst_rdata", l2_rdata, '0);
        chk("rst_strobes", LINE_W'({pmem_read, pmem_write, l2_resp, vc_resp}), '0);
        reset = 1'b0;
        step();

        // Lone fill, pmem answering 5 cycles after the strobe
        fixed_lat = 5; use_pat = 1'b1; rd_pat = {16{8'hA5}};
        l2_address = 16'h1238; l2_read = 1'b1;
        step();
        chk("fill_strobe", LINE_W'(pmem_read), LINE_W'(1'b1));
        chk("fill_addr", LINE_W'(pmem_address), LINE_W'(16'h1230));
        k = 1;
        while (!l2_resp && k < 40) begin step(); k++; end
        chk("fill_latency", LINE_W'(k), LINE_W'(7));
        chk("fill_data", l2_rdata, {16{8'hA5}});
        chk("fill_break_strobe", LINE_W'(pmem_read), '0);
        settle("fill");
        use_pat = 1'b0; fixed_lat = -1;

        // Read-after-write hazard on the same line
        clear_log();
        l2_address = 16'h4010; l2_read = 1'b1;
        vc_address = 16'h401C; vc_urgent = 1'b0; vc_wdata = rnd_line(); vc_write = 1'b1;
        settle("hazard");
        log_chk("haz_first", 0, 2, 16'h4010);
        log_chk("haz_second", 1, 1, 16'h4010);

        // Urgent eviction beats a simultaneous fill
        clear_log();
        l2_address = 16'h2000; l2_read = 1'b1;
        vc_address = 16'h3000; vc_urgent = 1'b1; vc_wdata = rnd_line(); vc_write = 1'b1;
        settle("urgent");
        log_chk("urg_first", 0, 2, 16'h3000);
        log_chk("urg_second", 1, 1, 16'h2000);

        // Starvation: back-to-back fills against a waiting cleaning write
        clear_log();
        vc_address = 16'h5000; vc_urgent = 1'b0; vc_wdata = rnd_line(); vc_write = 1'b1;
        a = 16'h6000; l2_address = a; l2_read = 1'b1;
        l2_gap = 1'b0; w_seen = 1'b0; k = 0;
        while (vc_write && k < 300) begin
            step(); k++;
            if (pmem_write && !w_seen) begin
                w_seen = 1'b1;
                chk("starve_clear", LINE_W'(dut.starve_cnt), '0);
            end
            if (!l2_read && vc_write) begin
                if (l2_gap) begin
                    a = a + 16'h10; l2_address = a; l2_read = 1'b1; l2_gap = 1'b0;
                end else l2_gap = 1'b1;
            end
        end
        settle("starve");
        for (int i = 0; i < 4; i++) log_chk("starve_rd", i, 1, 16'h6000 + 16'(i * 16));
        log_chk("starve_wr", 4, 2, 16'h5000);

        // Idle cleaning: write data is the value present at grant
        fixed_lat = 3; w1 = rnd_line();
        vc_address = 16'h7008; vc_urgent = 1'b0; vc_wdata = w1; vc_write = 1'b1;
        step();
        chk("clean_grant", LINE_W'(pmem_write), LINE_W'(1'b1));
        chk("clean_addr", LINE_W'(pmem_address), LINE_W'(16'h7000));
        chk("clean_wdata", pmem_wdata, w1);
        vc_wdata = ~w1;
        step();
        chk("clean_hold", pmem_wdata, w1);
        settle("clean");

        // Reset while a fill is outstanding, then a late pmem_resp
        fixed_lat = 20;
        l2_address = 16'h1238; l2_read = 1'b1;
        step(); step();
        chk("rst_mid_pre", LINE_W'(pmem_read), LINE_W'(1'b1));
        reset = 1'b1; l2_read = 1'b0;
        step();
        reset = 1'b0;
        chk("rst_mid_strobe", LINE_W'({pmem_read, pmem_write}), '0);
        chk("rst_mid_addr", LINE_W'(pmem_address), '0);
        chk("rst_mid_rdata", l2_rdata, '0);
        chk("rst_mid_wdata", pmem_wdata, '0);
        pmem_resp = 1'b1; pmem_rdata = rnd_line();
        step();
        chk("rst_late_resp", LINE_W'(l2_resp), '0);
        step();
        chk("rst_late_resp2", LINE_W'(l2_resp), '0);
        fixed_lat = -1;
        settle("reset_mid");

        // Randomized traffic with occasional resets and stray pmem_resp pulses
        spurious = 1'b1; p_l2 = 35; p_vc = 25;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1; l2_read = 1'b0; vc_write = 1'b0;
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end
        p_l2 = 0; p_vc = 0; spurious = 1'b0;
        settle("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
